// File: rtl/micro_sequencer_axi_writer.sv
// ---------------------------------------------------------------------------
// micro_sequencer_axi_writer
//
// Single-outstanding AXI4-Lite write master. Each one-cycle write request
// from the micro-sequencer (axi_write with axi_waddr/axi_wdata/axi_wstrb)
// becomes one AW/W/B transaction. axi_waddr is relative and has
// C_M_AXI_ADDR_OFFSET added to it (wrapping at 2^C_M_AXI_ADDR_WIDTH).
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET   clock, synchronous active-high reset
//   axi_wdata/axi_waddr/axi_wstrb/axi_write   request from the sequencer
//   axi_write_busy             transaction in flight (request would be dropped)
//   axi_write_failed           sticky error for the last request: error
//                              response, overrun or response timeout
//   M_AXI_AW*/W*/B*            AXI4-Lite write channels (all outputs registered)
//
// Optional feature: define MICRO_SEQ_AXI_TIMEOUT_EN to abandon a transaction
// whose B response has not arrived TIMEOUT_CYCLES clocks after entering
// RESP. Without it RESP waits indefinitely and no counter is built.
// ---------------------------------------------------------------------------
module micro_sequencer_axi_writer #(
    parameter int                            C_M_AXI_DATA_WIDTH  = 32,
    parameter int                            C_M_AXI_ADDR_WIDTH  = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_AXI_ADDR_OFFSET = 'h4000_0000,
    parameter int                            TIMEOUT_CYCLES      = 1024
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic [31:0]                   axi_wdata,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] axi_waddr,
    input  logic [3:0]                    axi_wstrb,
    input  logic                          axi_write,
    output logic                          axi_write_busy,
    output logic                          axi_write_failed,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [31:0]                   M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY
);

    // Elaboration-time sanity checks on the configuration.
    generate
        if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("micro_sequencer_axi_writer: data width must be 32");
        end
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
            $error("micro_sequencer_axi_writer: TIMEOUT_CYCLES out of 1..65536");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_RESP} state_t;

    state_t                          state_q, state_d;
    logic                            aw_done_q, aw_done_d;
    logic                            w_done_q, w_done_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            bready_q, bready_d;
    logic                            busy_q, busy_d;
    logic                            failed_q, failed_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [31:0]                     wdata_q, wdata_d;
    logic [3:0]                      wstrb_q, wstrb_d;

    logic aw_hs;
    logic w_hs;
    logic timeout_hit;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q & M_AXI_WREADY;

`ifdef MICRO_SEQ_AXI_TIMEOUT_EN
    logic [15:0] timeout_cnt_q, timeout_cnt_d;

    // Counter is zero on RESP entry, so the hit fires on the last of
    // TIMEOUT_CYCLES RESP clocks.
    assign timeout_hit   = (state_q == S_RESP) &&
                           (timeout_cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_cnt_d = (state_q == S_RESP) ? timeout_cnt_q + 16'd1 : 16'd0;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            timeout_cnt_q <= 16'd0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b1;
            busy_q    <= 1'b0;
            failed_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            busy_q    <= busy_d;
            failed_q  <= failed_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE: begin
                if (axi_write) begin
                    state_d   = S_XFER;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_XFER: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // BREADY is always high in RESP, so BVALID alone completes.
                if (M_AXI_BVALID || timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----
    always_comb begin
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        busy_d    = busy_q;
        failed_d  = failed_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        case (state_q)
            S_IDLE: begin
                // Stray BVALID here is drained by BREADY=1 and ignored.
                if (axi_write) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    busy_d    = 1'b1;
                    failed_d  = 1'b0;
                    awaddr_d  = axi_waddr + C_M_AXI_ADDR_OFFSET;
                    wdata_d   = axi_wdata;
                    wstrb_d   = axi_wstrb;
                end
            end
            S_XFER: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (axi_write) failed_d = 1'b1;   // overrun: request dropped
            end
            S_RESP: begin
                if (M_AXI_BVALID) begin
                    busy_d = 1'b0;
                    if (M_AXI_BRESP != 2'b00) failed_d = 1'b1;
                end else if (timeout_hit) begin
                    busy_d   = 1'b0;
                    failed_d = 1'b1;
                end
                if (axi_write) failed_d = 1'b1;   // overrun: request dropped
            end
            default: begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
        // BREADY is registered from the next state: low only while in XFER.
        bready_d = (state_d != S_XFER);
    end

    assign axi_write_busy   = busy_q;
    assign axi_write_failed = failed_q;
    assign M_AXI_AWADDR     = awaddr_q;
    assign M_AXI_AWPROT     = 3'b000;
    assign M_AXI_AWVALID    = awvalid_q;
    assign M_AXI_WDATA      = wdata_q;
    assign M_AXI_WSTRB      = wstrb_q;
    assign M_AXI_WVALID     = wvalid_q;
    assign M_AXI_BREADY     = bready_q;

endmodule

// File: doc/micro_sequencer_axi_writer.md
# micro_sequencer_axi_writer

Single-outstanding AXI4-Lite write master that carries out the register writes requested by the micro-sequencer's write port (`axi_wdata`/`axi_waddr`/`axi_wstrb`/`axi_write`). It sits directly downstream of the sequencer. It translates each one-cycle write request into a full AW/W/B transaction on the PS/PL interconnect. It returns `axi_write_busy` and `axi_write_failed` so the sequencer can stall or flag errors.

## Interface
- `C_M_AXI_DATA_WIDTH`, 32: data width; must be 32.
- `C_M_AXI_ADDR_WIDTH`, 32: address width.
- `C_M_AXI_ADDR_OFFSET`, 32'h4000_0000: base added to every request address.
- `TIMEOUT_CYCLES`, 1024: response timeout in clocks; used only with the timeout macro.

Ports:
- `M_AXI_ACLK` in 1: the only clock.
- `M_AXI_ARESET` in 1: synchronous, active-high reset.
- `axi_wdata` in 32: write data from the sequencer.
- `axi_waddr` in C_M_AXI_ADDR_WIDTH: address from the sequencer, relative to the offset.
- `axi_wstrb` in 4: byte strobes.
- `axi_write` in 1: one-cycle request strobe.
- `axi_write_busy` out 1: a transaction is in flight.
- `axi_write_failed` out 1: sticky error for the last request.
- `M_AXI_AWADDR` out C_M_AXI_ADDR_WIDTH; `M_AXI_AWPROT` out 3 (constant 3'b000); `M_AXI_AWVALID` out 1; `M_AXI_AWREADY` in 1.
- `M_AXI_WDATA` out 32; `M_AXI_WSTRB` out 4; `M_AXI_WVALID` out 1; `M_AXI_WREADY` in 1.
- `M_AXI_BRESP` in 2; `M_AXI_BVALID` in 1; `M_AXI_BREADY` out 1.

## Operation
- States:
  - IDLE: waiting for a request.
  - XFER: AW and/or W channel not yet accepted.
  - RESP: both channels accepted, waiting for B.
- IDLE, `axi_write`=1:
  - Latch `axi_waddr + C_M_AXI_ADDR_OFFSET` (mod 2^C_M_AXI_ADDR_WIDTH), `axi_wdata` and `axi_wstrb`.
  - Assert AWVALID and WVALID, set busy, clear failed, go to XFER.
- XFER channel handling:
  - AW and W are tracked independently via `aw_done`/`w_done` flags.
  - Each VALID drops on the cycle after its own handshake (VALID&READY); it never drops before that handshake.
  - AW and W handshakes may occur in either order or in the same cycle.
  - When both flags are set, go to RESP.
- BREADY:
  - Held 1 in RESP and in IDLE, so stray or late responses are drained.
  - Held 0 in XFER.
- RESP, BVALID=1:
  - Failed is set if `BRESP != 2'b00` (SLVERR/DECERR); an OKAY response leaves it clear.
  - Clear busy and go to IDLE.
- `axi_write` while busy: the request is dropped, no AXI activity occurs, and failed is set (overrun). The in-flight transaction continues unaffected.
- BVALID seen in IDLE: the response is accepted and discarded; failed and busy are unchanged.
- Payload registers hold their values until the next accepted request.
- Reset mid-transaction: the block returns to IDLE immediately, all VALIDs drop and the latched request is discarded. The system must reset the interconnect together with this block.

## Timing
- Reset values:
  - `M_AXI_AWVALID`, `M_AXI_WVALID`, `axi_write_busy`, `axi_write_failed` = 0.
  - `M_AXI_AWADDR`, `M_AXI_WDATA`, `M_AXI_WSTRB` = 0.
  - `M_AXI_BREADY` = 1.
- Request sampled on edge t:
  - AWVALID, WVALID and busy are high from t+1.
  - Best case: AW and W accepted at t+1, BVALID at t+2, busy low at t+3. Minimum request-to-idle is 3 clocks.
- A new request is accepted in the same cycle busy reads 0.
- All outputs are registered; there is no combinational path from AXI inputs to AXI outputs.

## Configuration
- `MICRO_SEQ_AXI_TIMEOUT_EN` defined:
  - A 16-bit counter runs in RESP.
  - After TIMEOUT_CYCLES clocks with no BVALID, set failed, clear busy and go to IDLE.
  - A late response is then drained in IDLE.
  - XFER is never timed out, to preserve AXI VALID-stability rules.
- Undefined: RESP waits indefinitely and no counter logic is built.

## Test plan
- Basic write, all READY=1, BRESP=OKAY:
  - Stimulus: waddr=0x10, wdata=0xDEADBEEF, wstrb=0xF.
  - Required: AWADDR=0x4000_0010 and WDATA=0xDEADBEEF at t+1; busy high for t+1..t+2; failed=0.
- AWREADY delayed 5 clocks, WREADY immediate:
  - Required: WVALID drops at t+2; AWVALID holds until its handshake; exactly one B accepted.
- BRESP=2'b10 → failed=1 after completion; next OKAY request → failed=0.
- Overrun: second `axi_write` at t+1 with wdata=0x1234 → no second AW; failed=1; first transaction completes.
- Address wrap: waddr=0xC000_0004 → AWADDR=0x0000_0004.
- Timeout, with `MICRO_SEQ_AXI_TIMEOUT_EN` and TIMEOUT_CYCLES=8, BVALID withheld:
  - Required: busy low and failed=1 at RESP entry+8.
  - A later BVALID is accepted in IDLE without changing state.
